// File: rtl/t5_dwbs_pkg.sv
// t5_dwbs_pkg: shared definitions for the t5 data-bus responder.
//   - state_e      : responder FSM states (IDLE / WAIT / ACK, 2-bit)
//   - XLEN_DEFAULT : default data/address width
//   - CNT_W        : width of the wait-state counter (WAIT up to 15)
//   - wait_load()  : value loaded into the wait counter when leaving IDLE
package t5_dwbs_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // WAIT=0 never enters ST_WAIT, so its load value is irrelevant.
  function automatic logic [CNT_W-1:0] wait_load(input int w);
    return (w > 0) ? CNT_W'(w - 1) : '0;
  endfunction

endpackage

// File: rtl/t5_sram.sv
// t5_sram: single-port word RAM with per-byte write enables and a
// synchronous, enabled read register.
//   clk_i    : clock
//   rst_i    : synchronous active-high clear of the read register only
//   wr_en_i  : write the lanes selected by sel_i at addr_i
//   rd_en_i  : capture mem[addr_i] into rdata_o
//   sel_i    : byte-lane write enables
//   addr_i   : word address
//   wdata_i  : write data
//   rdata_o  : registered read data, holds its value when rd_en_i is low
module t5_sram #(
  parameter int XLEN = 32,
  parameter int AW   = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [XLEN/8-1:0] sel_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem [2**AW];
  logic [XLEN-1:0] rdata_q;

  // NOTE: the array has no reset branch; clearing it would force a
  // flop-based implementation instead of a RAM macro, and contents are
  // allowed to survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NB; i++) begin
        if (sel_i[i]) mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i)        rdata_q <= '0;
    else if (rd_en_i) rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/t5_dwbs.sv
// t5_dwbs: data-bus responder for the t5 core. Answers each dwb_stb
// request with a single registered dwb_ack pulse after WAIT extra cycles,
// backed by a 2^AW-word local RAM.
//   sys_clk : clock (rising edge)
//   sys_rst : synchronous active-high reset
//   dwb_stb : request strobe, held until ack
//   dwb_wre : 1 = write, 0 = read
//   dwb_sel : byte enables for writes
//   dwb_adr : byte address, only [AW+1:2] used (aliases modulo 2^AW words)
//   dwb_dto : write data
//   dwb_dti : registered read data, valid in the ack cycle, held otherwise
//   dwb_ack : one-cycle transfer-complete pulse
module t5_dwbs
  import t5_dwbs_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int AW   = 10,
  parameter int WAIT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              dwb_stb,
  input  logic              dwb_wre,
  input  logic [XLEN/8-1:0] dwb_sel,
  input  logic [XLEN-1:0]   dwb_adr,
  input  logic [XLEN-1:0]   dwb_dto,
  output logic [XLEN-1:0]   dwb_dti,
  output logic              dwb_ack
);

  localparam logic [CNT_W-1:0] WaitLoad = wait_load(WAIT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q;
  logic             commit;
  logic             unused_adr;

  // Byte offset and bits above the RAM window are deliberately ignored.
  assign unused_adr = ^{dwb_adr[XLEN-1:AW+2], dwb_adr[1:0]};

  // commit is high exactly on the edge that enters ACK: the one point
  // where the request is written to / read from the RAM.
  always_comb begin
    // NOTE: default assignment first so no path leaves commit unassigned,
    // which would otherwise infer a latch.
    commit = 1'b0;
    case (state_q)
      ST_IDLE: commit = dwb_stb && (WAIT == 0);
      ST_WAIT: commit = dwb_stb && (cnt_q == '0);
      default: commit = 1'b0;
    endcase
    if (sys_rst) commit = 1'b0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= commit;
      case (state_q)
        ST_IDLE: begin
          if (dwb_stb) begin
            if (WAIT == 0) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WaitLoad;
            end
          end
        end
        ST_WAIT: begin
          // A dropped strobe aborts: no ack, and commit stayed low.
          if (!dwb_stb)            state_q <= ST_IDLE;
          else if (cnt_q == '0)    state_q <= ST_ACK;
          else                     cnt_q   <= cnt_q - 1'b1;
        end
        // Strobe is still high from the request just acked; ignore it.
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Reads only refresh dwb_dti; a write leaves the last read data in place.
  t5_sram #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_sram (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .wr_en_i (commit && dwb_wre),
    .rd_en_i (commit && !dwb_wre),
    .sel_i   (dwb_sel),
    .addr_i  (dwb_adr[AW+1:2]),
    .wdata_i (dwb_dto),
    .rdata_o (dwb_dti)
  );

  assign dwb_ack = ack_q;

endmodule
